frame_buf_sched: RTL and testbench

FRAME_BUF_SCHED -- requirements
Module: frame_buf_sched

---
 rtl/frame_buf_sched_if.sv | 26 ++
 rtl/frame_buf_sched.sv | 153 +++++++++++++++
 tb/tb_frame_buf_sched.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buf_sched_if.sv
// Strobe and address bundle between the frame buffer scheduler and its
// camera/display/SDRAM neighbours.
interface frame_buf_sched_if;
  logic        iWR_SOF;
  logic        iWR_PIX;
  logic        iRD_SOF;
  logic        iRD_PIX;
  logic [22:0] oWR_ADDR;
  logic [22:0] oRD_ADDR;
  logic        oWR_LOAD;
  logic        oRD_LOAD;
  logic        oWR_BUF;
  logic        oRD_BUF;
  logic        oDROP;
  logic [7:0]  oFRAME_CNT;

  modport slave (
    input  iWR_SOF, iWR_PIX, iRD_SOF, iRD_PIX,
    output oWR_ADDR, oRD_ADDR, oWR_LOAD, oRD_LOAD, oWR_BUF, oRD_BUF, oDROP, oFRAME_CNT
  );

  modport master (
    output iWR_SOF, iWR_PIX, iRD_SOF, iRD_PIX,
    input  oWR_ADDR, oRD_ADDR, oWR_LOAD, oRD_LOAD, oWR_BUF, oRD_BUF, oDROP, oFRAME_CNT
  );
endinterface

// File: rtl/frame_buf_sched.sv
// Double-buffered frame scheduler: camera fills one SDRAM buffer while the display reads the other.
// Optional macro FBS_FRAME_CNT_EN builds the display swap counter on oFRAME_CNT.
module frame_buf_sched #(
  parameter int          FRAME_PIXELS = 307200,
  parameter logic [22:0] BUF0_BASE    = 23'h000000,
  parameter logic [22:0] BUF1_BASE    = 23'h100000,
  parameter int          LOAD_CYCLES  = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  frame_buf_sched_if.slave  bus
);

  localparam int          LCW       = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);
  localparam logic [22:0] LAST_OFS  = 23'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {W_IDLE, W_LOAD, W_FILL, W_DONE} w_state_t;

  w_state_t       w_state_reg;
  logic           ready_reg;
  logic           wr_buf_reg;
  logic           rd_buf_reg;
  logic [22:0]    wr_addr_reg;
  logic [22:0]    rd_addr_reg;
  logic           wr_load_reg;
  logic           rd_load_reg;
  logic           drop_reg;
  logic [LCW-1:0] wr_cnt_reg;
  logic [LCW-1:0] rd_cnt_reg;

  logic        swap;
  logic        rd_buf_next;
  logic [22:0] wr_next_base;
  logic [22:0] wr_cur_base;
  logic [22:0] rd_next_base;
  logic [22:0] rd_cur_base;
  logic        wr_last;
  logic        rd_wrap;

  // The swap is resolved first so a writer starting in the same cycle
  // always lands on the buffer the display is not about to show.
  always_comb begin
    swap         = bus.iRD_SOF && ready_reg;
    rd_buf_next  = swap ? wr_buf_reg : rd_buf_reg;
    wr_next_base = rd_buf_next ? BUF0_BASE : BUF1_BASE;
    wr_cur_base  = wr_buf_reg  ? BUF1_BASE : BUF0_BASE;
    rd_next_base = rd_buf_next ? BUF1_BASE : BUF0_BASE;
    rd_cur_base  = rd_buf_reg  ? BUF1_BASE : BUF0_BASE;
    wr_last      = (wr_addr_reg == wr_cur_base + LAST_OFS);
    rd_wrap      = (rd_addr_reg == rd_cur_base + LAST_OFS);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      w_state_reg <= W_IDLE;
      ready_reg   <= 1'b0;
      wr_buf_reg  <= 1'b1;
      wr_addr_reg <= BUF1_BASE;
      wr_load_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      drop_reg    <= 1'b0;
    end else begin
      drop_reg <= 1'b0;
      if (swap) ready_reg <= 1'b0;
      case (w_state_reg)
        W_IDLE, W_DONE: begin
          if (bus.iWR_SOF) begin
            // An unshown finished frame is overwritten: report it.
            if (ready_reg && !swap) drop_reg <= 1'b1;
            ready_reg   <= 1'b0;
            wr_buf_reg  <= ~rd_buf_next;
            wr_addr_reg <= wr_next_base;
            wr_load_reg <= 1'b1;
            wr_cnt_reg  <= '0;
            w_state_reg <= W_LOAD;
          end
        end
        W_LOAD: begin
          if (bus.iWR_SOF) begin
            drop_reg    <= 1'b1;
            wr_addr_reg <= wr_cur_base;
            wr_load_reg <= 1'b1;
            wr_cnt_reg  <= '0;
          end else if (wr_cnt_reg == LOAD_LAST) begin
            wr_load_reg <= 1'b0;
            w_state_reg <= W_FILL;
          end else begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
          end
        end
        W_FILL: begin
          if (bus.iWR_SOF) begin
            drop_reg    <= 1'b1;
            wr_addr_reg <= wr_cur_base;
            wr_load_reg <= 1'b1;
            wr_cnt_reg  <= '0;
            w_state_reg <= W_LOAD;
          end else if (bus.iWR_PIX) begin
            wr_addr_reg <= wr_addr_reg + 23'd1;
            if (wr_last) begin
              w_state_reg <= W_DONE;
              ready_reg   <= 1'b1;
            end
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_buf_reg  <= 1'b0;
      rd_addr_reg <= BUF0_BASE;
      rd_load_reg <= 1'b0;
      rd_cnt_reg  <= '0;
    end else if (bus.iRD_SOF) begin
      rd_buf_reg  <= rd_buf_next;
      rd_addr_reg <= rd_next_base;
      rd_load_reg <= 1'b1;
      rd_cnt_reg  <= '0;
    end else if (rd_load_reg) begin
      if (rd_cnt_reg == LOAD_LAST) rd_load_reg <= 1'b0;
      else                         rd_cnt_reg  <= rd_cnt_reg + 1'b1;
    end else if (bus.iRD_PIX) begin
      // The display scans the same frame repeatedly until the next swap.
      rd_addr_reg <= rd_wrap ? rd_cur_base : rd_addr_reg + 23'd1;
    end
  end

`ifdef FBS_FRAME_CNT_EN
  logic [7:0] frame_cnt_reg;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)      frame_cnt_reg <= 8'd0;
    else if (swap) frame_cnt_reg <= frame_cnt_reg + 8'd1;
  end

  assign bus.oFRAME_CNT = frame_cnt_reg;
`else
  assign bus.oFRAME_CNT = 8'd0;
`endif

  assign bus.oWR_ADDR = wr_addr_reg;
  assign bus.oRD_ADDR = rd_addr_reg;
  assign bus.oWR_LOAD = wr_load_reg;
  assign bus.oRD_LOAD = rd_load_reg;
  assign bus.oWR_BUF  = wr_buf_reg;
  assign bus.oRD_BUF  = rd_buf_reg;
  assign bus.oDROP    = drop_reg;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Scoreboard bench for frame_buf_sched: directed scenarios then randomized
// strobes, checked against a frame/pixel-count reference model.
module tb_frame_buf_sched;
  localparam int          FP = 4;
  localparam int          LC = 2;
  localparam logic [22:0] B0 = 23'h000000;
  localparam logic [22:0] B1 = 23'h100000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_buf_sched_if bus ();

  frame_buf_sched #(
    .FRAME_PIXELS(FP),
    .BUF0_BASE   (B0),
    .BUF1_BASE   (B1),
    .LOAD_CYCLES (LC)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  typedef struct {
    logic [22:0] wr_addr;
    logic [22:0] rd_addr;
    logic        wr_load;
    logic        rd_load;
    logic        wr_buf;
    logic        rd_buf;
    logic        drop;
    logic [7:0]  fc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int txn   = 0;

  // Reference model: writer phase 0 idle, 1 loading, 2 filling, 3 done.
  int m_phase, m_wload, m_wpix, m_wbuf, m_rbuf, m_ready, m_rload, m_rpos, m_fc, m_drop;

  function automatic logic [22:0] base_of(input int b);
    return (b != 0) ? B1 : B0;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.wr_addr = base_of(m_wbuf) + 23'(m_wpix);
    e.rd_addr = base_of(m_rbuf) + 23'(m_rpos);
    e.wr_load = (m_wload > 0);
    e.rd_load = (m_rload > 0);
    e.wr_buf  = (m_wbuf != 0);
    e.rd_buf  = (m_rbuf != 0);
    e.drop    = (m_drop != 0);
    e.fc      = 8'(m_fc);
    return e;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_wload = 0; m_wpix = 0; m_wbuf = 1; m_rbuf = 0;
    m_ready = 0; m_rload = 0; m_rpos = 0; m_fc = 0;  m_drop = 0;
  endtask

  task automatic model_step(input logic ws, input logic wp, input logic rs, input logic rp);
    int ready_old;
    int swap;
    ready_old = m_ready;
    swap = (rs && ready_old != 0) ? 1 : 0;
    m_drop = 0;
    if (swap != 0) begin
      m_rbuf  = 1 - m_rbuf;
      m_ready = 0;
`ifdef FBS_FRAME_CNT_EN
      m_fc = (m_fc + 1) % 256;
`endif
    end
    if (ws) begin
      if (m_phase == 0 || m_phase == 3) begin
        if (ready_old != 0 && swap == 0) m_drop = 1;
        m_ready = 0;
        m_wbuf  = 1 - m_rbuf;
      end else begin
        m_drop = 1;
      end
      m_phase = 1; m_wload = LC; m_wpix = 0;
    end else if (m_phase == 1) begin
      m_wload = m_wload - 1;
      if (m_wload == 0) m_phase = 2;
    end else if (m_phase == 2 && wp) begin
      m_wpix = m_wpix + 1;
      if (m_wpix == FP) begin
        m_phase = 3;
        m_ready = 1;
      end
    end
    if (rs) begin
      m_rpos = 0; m_rload = LC;
    end else if (m_rload > 0) begin
      m_rload = m_rload - 1;
    end else if (rp) begin
      m_rpos = (m_rpos + 1) % FP;
    end
  endtask

  task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all(input exp_t e);
    txn++;
    $display("[TB] txn %0d wr_addr=%h rd_addr=%h wr_load=%b rd_load=%b wr_buf=%b rd_buf=%b drop=%b fc=%0d",
             txn, bus.oWR_ADDR, bus.oRD_ADDR, bus.oWR_LOAD, bus.oRD_LOAD,
             bus.oWR_BUF, bus.oRD_BUF, bus.oDROP, bus.oFRAME_CNT);
    chk("wr_addr",   bus.oWR_ADDR,   e.wr_addr);
    chk("rd_addr",   bus.oRD_ADDR,   e.rd_addr);
    chk("wr_load",   23'(bus.oWR_LOAD), 23'(e.wr_load));
    chk("rd_load",   23'(bus.oRD_LOAD), 23'(e.rd_load));
    chk("wr_buf",    23'(bus.oWR_BUF),  23'(e.wr_buf));
    chk("rd_buf",    23'(bus.oRD_BUF),  23'(e.rd_buf));
    chk("drop",      23'(bus.oDROP),    23'(e.drop));
    chk("frame_cnt", 23'(bus.oFRAME_CNT), 23'(e.fc));
  endtask

  // Monitor: compares every registered update against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare_all(e);
      end
    end
  end

  task automatic step(input logic ws, input logic wp, input logic rs, input logic rp);
    @(negedge clk);
    bus.iWR_SOF = ws;
    bus.iWR_PIX = wp;
    bus.iRD_SOF = rs;
    bus.iRD_PIX = rp;
    model_step(ws, wp, rs, rp);
    q.push_back(snap());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.iWR_SOF = 1'b0; bus.iWR_PIX = 1'b0; bus.iRD_SOF = 1'b0; bus.iRD_PIX = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all(snap());
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_frame();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LC; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < FP; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [22:0] rd_seq [6];
    bus.iWR_SOF = 1'b0; bus.iWR_PIX = 1'b0; bus.iRD_SOF = 1'b0; bus.iRD_PIX = 1'b0;
    rd_seq[0] = 23'h100001; rd_seq[1] = 23'h100002; rd_seq[2] = 23'h100003;
    rd_seq[3] = 23'h100000; rd_seq[4] = 23'h100001; rd_seq[5] = 23'h100002;

    do_reset();

    // First frame into buffer 1; pixels during the load pulse are ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("sof_wr_load", 23'(bus.oWR_LOAD), 23'd1);
    chk("sof_wr_addr", bus.oWR_ADDR, 23'h100000);
    for (int i = 0; i < LC; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < FP; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("frame_end_addr", bus.oWR_ADDR, 23'h100004);
    chk("frame_end_load", 23'(bus.oWR_LOAD), 23'd0);

    // Display swap onto buffer 1.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("swap_rd_buf", 23'(bus.oRD_BUF), 23'd1);
    chk("swap_rd_addr", bus.oRD_ADDR, 23'h100000);
    chk("swap_rd_load", 23'(bus.oRD_LOAD), 23'd1);
    for (int i = 0; i < LC; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("rd_load_end", 23'(bus.oRD_LOAD), 23'd0);
    chk("rd_addr_hold", bus.oRD_ADDR, 23'h100000);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      settle();
      chk("rd_wrap_seq", bus.oRD_ADDR, rd_seq[i]);
    end

    // Two frames without a display swap: the second start drops the first.
    write_frame();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("overrun_drop", 23'(bus.oDROP), 23'd1);
    chk("overrun_wr_buf", 23'(bus.oWR_BUF), 23'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("drop_one_cycle", 23'(bus.oDROP), 23'd0);

    // Abort after two pixels.
    for (int i = 0; i < LC - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("abort_drop", 23'(bus.oDROP), 23'd1);
    chk("abort_addr", bus.oWR_ADDR, 23'h000000);

    // Finish that frame, then simultaneous swap and new write.
    for (int i = 0; i < LC; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FP; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("both_sof_rd_buf", 23'(bus.oRD_BUF), 23'd0);
    chk("both_sof_wr_buf", 23'(bus.oWR_BUF), 23'd1);
    chk("both_sof_drop", 23'(bus.oDROP), 23'd0);
    chk("both_sof_wr_addr", bus.oWR_ADDR, 23'h100000);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 700; i++) begin
      if (i == 350) begin
        do_reset();
      end else begin
        step($urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) == 0,  $urandom_range(0, 1) == 1);
      end
    end

    step(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("scoreboard_drained", 23'(q.size()), 23'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
